// File: rtl/nf10_upb_arb_pkg.sv
// nf10_upb_arb_pkg
// Shared definitions for the nf10_upb input arbiter:
//   - AXI-Stream field widths and the packed slice payload width
//   - grant FSM state encoding
//   - round-robin next-index helper
package nf10_upb_arb_pkg;

    localparam int TDATA_W   = 256;
    localparam int TKEEP_W   = 32;
    localparam int INPORT_W  = 3;
    localparam int VPORT_W   = 3;
    localparam int PLEN_W    = 14;
    localparam int OUTPORT_W = 8;

    // tdata | tkeep | in_port | in_vport | packet_length | tlast
    localparam int PAYLOAD_W = TDATA_W + TKEEP_W + INPORT_W + VPORT_W + PLEN_W + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Index following idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/nf10_upb_axis_reg_slice.sv
// nf10_upb_axis_reg_slice
// Two-entry skid buffer for an AXI-Stream payload. Every output is a flop:
// out_data/out_valid come from the head entry, in_ready is the inverse of the
// second-entry valid bit. Sustains one beat per cycle while out_ready is high.
// Ports:
//   clk, rst           clock, synchronous active-high reset (empties buffer)
//   in_data/valid/ready   upstream handshake, W-bit payload
//   out_data/valid/ready  downstream handshake, W-bit payload
module nf10_upb_axis_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic         v0_q, v0_d;
    logic         v1_q, v1_d;
    logic         push, pop;

    assign in_ready  = ~v1_q;
    assign out_valid = v0_q;
    assign out_data  = e0_q;

    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        push = in_valid & ~v1_q;
        pop  = v0_q & out_ready;

        if (pop) begin
            if (v1_q) begin
                // Full: push is blocked, second entry shifts into the head.
                e0_d = e1_q;
                v1_d = 1'b0;
            end else if (push) begin
                e0_d = in_data;
            end else begin
                v0_d = 1'b0;
            end
        end else if (push) begin
            if (!v0_q) begin
                e0_d = in_data;
                v0_d = 1'b1;
            end else begin
                e1_d = in_data;
                v1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q <= '0;
            e1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

endmodule

// File: rtl/nf10_upb_input_arbiter.sv
// nf10_upb_input_arbiter
// Packet-granular round-robin merge of C_NUM_INPUTS AXI-Stream sources into
// one stream. A grant is held from the first beat through tlast; the merged
// stream leaves through a registered two-entry slice.
//
// Build option: define NF10_UPB_ARB_STRICT_PRIO_EN to give input C_PRIO_PORT
// strict priority in IDLE (rr_ptr is left untouched after its packets).
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   s_axis_*                 N packed slave streams (field i at i*W +: W)
//   s_axis_tready            one-hot (or zero) per-input ready
//   m_axis_*                 merged master stream, all outputs registered
//   m_axis_tuser_out_port/vport  tied to zero
//
// state     | meaning
// ST_IDLE   | no grant; pick winner from rr_ptr upward, all tready low
// ST_LOCKED | grant held; granted input feeds slice until tlast accepted
module nf10_upb_input_arbiter
    import nf10_upb_arb_pkg::*;
#(
    parameter int C_NUM_INPUTS = 5,
    parameter int C_PRIO_PORT  = 4
) (
    input  logic                             CLK,
    input  logic                             RST,

    input  logic [C_NUM_INPUTS*TDATA_W-1:0]  s_axis_tdata,
    input  logic [C_NUM_INPUTS*TKEEP_W-1:0]  s_axis_tkeep,
    input  logic [C_NUM_INPUTS*INPORT_W-1:0] s_axis_tuser_in_port,
    input  logic [C_NUM_INPUTS*VPORT_W-1:0]  s_axis_tuser_in_vport,
    input  logic [C_NUM_INPUTS*PLEN_W-1:0]   s_axis_tuser_packet_length,
    input  logic [C_NUM_INPUTS-1:0]          s_axis_tvalid,
    output logic [C_NUM_INPUTS-1:0]          s_axis_tready,
    input  logic [C_NUM_INPUTS-1:0]          s_axis_tlast,

    output logic [TDATA_W-1:0]               m_axis_tdata,
    output logic [TKEEP_W-1:0]               m_axis_tkeep,
    output logic [INPORT_W-1:0]              m_axis_tuser_in_port,
    output logic [VPORT_W-1:0]               m_axis_tuser_in_vport,
    output logic [PLEN_W-1:0]                m_axis_tuser_packet_length,
    output logic [OUTPORT_W-1:0]             m_axis_tuser_out_port,
    output logic [OUTPORT_W-1:0]             m_axis_tuser_out_vport,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast
);

    localparam int PTR_W = (C_NUM_INPUTS > 1) ? $clog2(C_NUM_INPUTS) : 1;

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] win;

    logic [2*C_NUM_INPUTS-1:0] req_dbl;
    logic [C_NUM_INPUTS-1:0]   req_rot;

    logic                 g_valid;
    logic                 g_last;
    logic [TDATA_W-1:0]   g_tdata;
    logic [TKEEP_W-1:0]   g_tkeep;
    logic [INPORT_W-1:0]  g_port;
    logic [VPORT_W-1:0]   g_vport;
    logic [PLEN_W-1:0]    g_plen;

    logic                 slice_in_valid;
    logic                 slice_in_ready;
    logic [PAYLOAD_W-1:0] slice_in_data;
    logic [PAYLOAD_W-1:0] slice_out_data;

    // Rotate requests so bit k means input (rr_ptr + k) mod N; the lowest set
    // bit of the rotated vector is the round-robin winner.
    assign req_dbl = {s_axis_tvalid, s_axis_tvalid};
    assign req_rot = C_NUM_INPUTS'(req_dbl >> rr_ptr_q);

    always_comb begin
        int  pos;
        logic found;
        pos   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < C_NUM_INPUTS; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                pos   = int'(rr_ptr_q) + k;
                if (pos >= C_NUM_INPUTS) begin
                    pos = pos - C_NUM_INPUTS;
                end
                win = PTR_W'(pos);
            end
        end
`ifdef NF10_UPB_ARB_STRICT_PRIO_EN
        if (s_axis_tvalid[C_PRIO_PORT]) begin
            win = PTR_W'(C_PRIO_PORT);
        end
`endif
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_tdata = '0;
        g_tkeep = '0;
        g_port  = '0;
        g_vport = '0;
        g_plen  = '0;
        for (int i = 0; i < C_NUM_INPUTS; i++) begin
            if (grant_q == PTR_W'(i)) begin
                g_valid = s_axis_tvalid[i];
                g_last  = s_axis_tlast[i];
                g_tdata = s_axis_tdata[i*TDATA_W +: TDATA_W];
                g_tkeep = s_axis_tkeep[i*TKEEP_W +: TKEEP_W];
                g_port  = s_axis_tuser_in_port[i*INPORT_W +: INPORT_W];
                g_vport = s_axis_tuser_in_vport[i*VPORT_W +: VPORT_W];
                g_plen  = s_axis_tuser_packet_length[i*PLEN_W +: PLEN_W];
            end
        end
    end

    assign slice_in_data = {g_tdata, g_tkeep, g_port, g_vport, g_plen, g_last};

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        s_axis_tready  = '0;
        slice_in_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d = win;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                for (int i = 0; i < C_NUM_INPUTS; i++) begin
                    if (grant_q == PTR_W'(i)) begin
                        s_axis_tready[i] = slice_in_ready;
                    end
                end
                slice_in_valid = g_valid;
                if (g_valid && slice_in_ready && g_last) begin
                    state_d = ST_IDLE;
`ifdef NF10_UPB_ARB_STRICT_PRIO_EN
                    if (grant_q != PTR_W'(C_PRIO_PORT)) begin
                        rr_ptr_d = PTR_W'(rr_next(int'(grant_q), C_NUM_INPUTS));
                    end
`else
                    rr_ptr_d = PTR_W'(rr_next(int'(grant_q), C_NUM_INPUTS));
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    nf10_upb_axis_reg_slice #(
        .W (PAYLOAD_W)
    ) u_slice (
        .clk       (CLK),
        .rst       (RST),
        .in_data   (slice_in_data),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .out_data  (slice_out_data),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser_in_port, m_axis_tuser_in_vport,
            m_axis_tuser_packet_length, m_axis_tlast} = slice_out_data;

    assign m_axis_tuser_out_port  = '0;
    assign m_axis_tuser_out_vport = '0;

endmodule

// File: tb/tb_nf10_upb_input_arbiter.sv
module tb_nf10_upb_input_arbiter;

    localparam int NI = 5;

    logic              clk;
    logic              rst;
    logic [NI*256-1:0] s_tdata;
    logic [NI*32-1:0]  s_tkeep;
    logic [NI*3-1:0]   s_port;
    logic [NI*3-1:0]   s_vport;
    logic [NI*14-1:0]  s_plen;
    logic [NI-1:0]     s_tvalid;
    logic [NI-1:0]     s_tready;
    logic [NI-1:0]     s_tlast;
    logic [255:0]      m_tdata;
    logic [31:0]       m_tkeep;
    logic [2:0]        m_port;
    logic [2:0]        m_vport;
    logic [13:0]       m_plen;
    logic [7:0]        m_oport;
    logic [7:0]        m_ovport;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    nf10_upb_input_arbiter #(.C_NUM_INPUTS(NI), .C_PRIO_PORT(4)) dut (
        .CLK                        (clk),
        .RST                        (rst),
        .s_axis_tdata               (s_tdata),
        .s_axis_tkeep               (s_tkeep),
        .s_axis_tuser_in_port       (s_port),
        .s_axis_tuser_in_vport      (s_vport),
        .s_axis_tuser_packet_length (s_plen),
        .s_axis_tvalid              (s_tvalid),
        .s_axis_tready              (s_tready),
        .s_axis_tlast               (s_tlast),
        .m_axis_tdata               (m_tdata),
        .m_axis_tkeep               (m_tkeep),
        .m_axis_tuser_in_port       (m_port),
        .m_axis_tuser_in_vport      (m_vport),
        .m_axis_tuser_packet_length (m_plen),
        .m_axis_tuser_out_port      (m_oport),
        .m_axis_tuser_out_vport     (m_ovport),
        .m_axis_tvalid              (m_tvalid),
        .m_axis_tready              (m_tready),
        .m_axis_tlast               (m_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [2:0]   port;
        logic [2:0]   vport;
        logic [13:0]  plen;
        logic         last;
    } beat_t;

    typedef struct {
        int          mask;
        int          npkt;
        int          beats;
        int          hold_at;
        int          hold_len;
        int          drop_src;
        int          drop_at;
        int          drop_len;
        bit          chk_gap;
        int          exp_n;
        logic [47:0] order;
    } tcase_t;

    beat_t     src_q[NI][$];
    beat_t     sb[$];
    int        exp_src[$];
    bit [NI-1:0] en;
    int        n_cmp = 0;
    int        n_mis = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int src, input int pkt, input int b, input bit last);
        beat_t r;
        r.data  = {8{8'(src), 8'(pkt), 8'(b), 8'hA5}};
        r.keep  = 32'hFFFF_FFFF >> b;
        r.port  = 3'(src);
        r.vport = 3'(pkt + b);
        r.plen  = 14'(64 * (b + 1) + src);
        r.last  = last;
        return r;
    endfunction

    function automatic tcase_t mkc(input int mask, input int npkt, input int beats,
                                   input int hold_at, input int hold_len,
                                   input int drop_src, input int drop_at, input int drop_len,
                                   input bit gap, input int n, input logic [47:0] ord);
        tcase_t c;
        c.mask = mask; c.npkt = npkt; c.beats = beats;
        c.hold_at = hold_at; c.hold_len = hold_len;
        c.drop_src = drop_src; c.drop_at = drop_at; c.drop_len = drop_len;
        c.chk_gap = gap; c.exp_n = n; c.order = ord;
        return c;
    endfunction

    task automatic load(input int src, input int npkt, input int beats, input int pkt_base);
        for (int p = 0; p < npkt; p++)
            for (int b = 0; b < beats; b++)
                src_q[src].push_back(mk(src, pkt_base + p, b, b == beats - 1));
    endtask

    task automatic clear_model();
        sb.delete();
        exp_src.delete();
        for (int i = 0; i < NI; i++) src_q[i].delete();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NI; i++) begin
            if (en[i] && src_q[i].size() > 0) begin
                s_tvalid[i]            = 1'b1;
                s_tlast[i]             = src_q[i][0].last;
                s_tdata[i*256 +: 256]  = src_q[i][0].data;
                s_tkeep[i*32 +: 32]    = src_q[i][0].keep;
                s_port[i*3 +: 3]       = src_q[i][0].port;
                s_vport[i*3 +: 3]      = src_q[i][0].vport;
                s_plen[i*14 +: 14]     = src_q[i][0].plen;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // Cycle loop: at each negedge check outputs against the occupancy model,
    // drive inputs, then record the handshakes that the next posedge completes.
    task automatic run(input tcase_t tc, input int stop_fires);
        int          fires = 0;
        int          last_fire = -1;
        bit          prev_last = 1'b0;
        bit          prev_stall = 1'b0;
        bit          open = 1'b0;
        bit          done = 1'b0;
        logic [255:0] prev_data = '0;
        beat_t       b;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            check("tvalid_vs_occupancy", m_tvalid, sb.size() != 0);
            check("tready_onehot", $countones(s_tready) <= 1, 1);
            if (sb.size() >= 2) check("tready_when_full", s_tready, 0);
            if (prev_stall) begin
                check("stall_tvalid", m_tvalid, 1);
                check("stall_tdata", m_tdata, prev_data);
            end
            if (open) check("other_tready_while_locked", s_tready & ~(NI'(1) << tc.drop_src), 0);

            for (int i = 0; i < NI; i++)
                en[i] = !(i == tc.drop_src && cyc >= tc.drop_at && cyc < tc.drop_at + tc.drop_len);
            m_tready = !(cyc >= tc.hold_at && cyc < tc.hold_at + tc.hold_len);
            drive_inputs();

            if (m_tvalid && m_tready) begin
                check("beat_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    b = sb.pop_front();
                    check("tdata", m_tdata, b.data);
                    check("tkeep", m_tkeep, b.keep);
                    check("in_port", m_port, b.port);
                    check("in_vport", m_vport, b.vport);
                    check("pkt_len", m_plen, b.plen);
                    check("tlast", m_tlast, b.last);
                    check("src_order", m_tdata[31:24], exp_src.size() != 0 ? 8'(exp_src[0]) : 8'hFF);
                    if (b.last && exp_src.size() != 0) void'(exp_src.pop_front());
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;

            for (int i = 0; i < NI; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    b = src_q[i][0];
                    if (tc.chk_gap && last_fire >= 0)
                        check("accept_gap", cyc - last_fire, prev_last ? 2 : 1);
                    if (i == tc.drop_src) open = !b.last;
                    sb.push_back(b);
                    void'(src_q[i].pop_front());
                    prev_last = b.last;
                    last_fire = cyc;
                    fires++;
                end
            end
            if (stop_fires > 0 && fires >= stop_fires) return;
            done = (sb.size() == 0) && (fires > 0);
            for (int i = 0; i < NI; i++) if (src_q[i].size() != 0) done = 1'b0;
        end
        check("case_complete", done, 1);
        check("order_consumed", exp_src.size(), 0);
    endtask

    localparam int NCASE = 6;
    tcase_t tcs[NCASE];

    initial begin
        logic [47:0] ord;
        tcase_t      c;
        rst      = 1'b1;
        s_tdata  = '0; s_tkeep = '0; s_port = '0; s_vport = '0; s_plen = '0;
        s_tvalid = '0; s_tlast = '0; m_tready = 1'b1; en = '1;

        //           mask      npkt beats hold   drop       gap n   order
        tcs[0] = mkc(5'b00101, 1, 3, -1, 0, -1, 0, 0, 1, 2,  48'h02);
        tcs[1] = mkc(5'b11111, 2, 1, -1, 0, -1, 0, 0, 1, 10, 48'h0123401234);
        tcs[2] = mkc(5'b00011, 1, 6,  3, 4, -1, 0, 0, 0, 2,  48'h01);
        tcs[3] = mkc(5'b00011, 1, 5, -1, 0,  0, 3, 3, 0, 2,  48'h01);
`ifdef NF10_UPB_ARB_STRICT_PRIO_EN
        tcs[4] = mkc(5'b10010, 3, 1, -1, 0, -1, 0, 0, 1, 6,  48'h444111);
`else
        tcs[4] = mkc(5'b10010, 3, 1, -1, 0, -1, 0, 0, 1, 6,  48'h141414);
`endif
        tcs[5] = mkc(5'b01100, 2, 2, -1, 0, -1, 0, 0, 1, 4,  48'h2323);

        // Reset values
        do_reset();
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tkeep", m_tkeep, 0);
        check("rst_m_in_port", m_port, 0);
        check("rst_m_in_vport", m_vport, 0);
        check("rst_m_pkt_len", m_plen, 0);
        check("rst_m_out_port", m_oport, 0);
        check("rst_m_out_vport", m_ovport, 0);
        check("rst_s_tready", s_tready, 0);

        for (int t = 0; t < NCASE; t++) begin
            do_reset();
            for (int s = 0; s < NI; s++)
                if (tcs[t].mask[s]) load(s, tcs[t].npkt, tcs[t].beats, 0);
            ord = tcs[t].order;
            for (int k = 0; k < tcs[t].exp_n; k++)
                exp_src.push_back(int'(ord[4*(tcs[t].exp_n-1-k) +: 4]));
            run(tcs[t], 0);
        end

        // Reset in the middle of a packet after rr_ptr has moved past input 0
        c = mkc(0, 0, 0, -1, 0, -1, 0, 0, 0, 0, 48'h0);
        do_reset();
        load(1, 1, 1, 0);
        exp_src.push_back(1);
        run(c, 0);
        load(1, 1, 4, 1);
        exp_src.push_back(1);
        run(c, 2);
        @(negedge clk);
        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        @(negedge clk);
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_s_tready", s_tready, 0);
        check("midrst_m_tlast", m_tlast, 0);
        rst = 1'b0;
        clear_model();
        load(0, 1, 2, 0);
        load(2, 1, 2, 0);
        exp_src.push_back(0);
        exp_src.push_back(2);
        c.chk_gap = 1'b1;
        run(c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
